// File: rtl/systolic_pkg.sv
// Shared configuration and types for the systolic array front end.
// Sets the array geometry, the activation element format and the feeder input buffer depth.
// Also holds the vector, per-row valid and feeder state types used across the slice.
package systolic_pkg;

  localparam int SYSTOLIC_ARRAY_ROWS = 8;   // rows fed, one element per row
  localparam int FIXED_POINT_WIDTH   = 16;  // Q8.8 two's complement, never modified here
  localparam int FIFO_DEPTH          = 4;   // input buffer depth in vectors, power of two >= 2
  localparam int FIFO_PTR_W          = $clog2(FIFO_DEPTH);
  // One spare bit so a single-row array still gets a legal counter width.
  localparam int DRAIN_CNT_W         = $clog2(SYSTOLIC_ARRAY_ROWS) + 1;

  typedef logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0] activation_vector_t;
  typedef logic [SYSTOLIC_ARRAY_ROWS-1:0]                        row_valid_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head entry is always visible on head_dat_o (show-ahead).
// Latency: an entry pushed at edge E is visible at the head after E, poppable at E+1.
// Backpressure: full_o/empty_o come from the registered count; push when full / pop when empty are ignored.
// Ports: clk_i, rst_n_i (async active-low), push_i + push_dat_i, pop_i, head_dat_o, full_o, empty_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/activation_skew_feeder.sv
// Buffers activation vectors and issues them diagonally skewed (row r delayed r cycles) to systolic_array.
// Latency: vector accepted at edge E pops at E+1 at the earliest; row r shows it r cycles after the pop.
// Backpressure: vector_ready_out = !fifo_full; stall_in freezes pops, skew chain and drain count.
// Ports: clk_in/rst_n_in, vector_{valid,ready,last}/vector_in upstream, stall_in,
//        activations_out/activations_valid_out to the array, busy_out, done_out (one-cycle end-of-drain pulse).
module activation_skew_feeder
  import systolic_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               vector_valid_in,
  output logic               vector_ready_out,
  input  activation_vector_t vector_in,
  input  logic               vector_last_in,
  input  logic               stall_in,
  output activation_vector_t activations_out,
  output row_valid_t         activations_valid_out,
  output logic               busy_out,
  output logic               done_out
);

  localparam int ROWS   = SYSTOLIC_ARRAY_ROWS;
  localparam int FIFO_W = 1 + ROWS * FIXED_POINT_WIDTH;
  localparam logic [DRAIN_CNT_W-1:0] LAST_CNT = DRAIN_CNT_W'(ROWS - 1);

  feeder_state_t            state_q, state_d;
  logic [DRAIN_CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  activation_vector_t       stage_dat_q [ROWS];
  logic [ROWS-1:0]          stage_vld_q;

  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  logic [FIFO_W-1:0]        head_dat;
  logic                     head_last;
  activation_vector_t       head_vec;

  assign vector_ready_out    = !fifo_full;
  assign push                = vector_valid_in && !fifo_full;
  assign pop                 = (state_q == STREAM) && !stall_in && !fifo_empty;
  assign {head_last, head_vec} = head_dat;
  assign busy_out            = (state_q != IDLE);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_PTR_W)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .push_i     (push),
    .push_dat_i ({vector_last_in, vector_in}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    done_out    = 1'b0;
    unique case (state_q)
      // Leave IDLE on the edge the FIFO becomes non-empty, so the first pop
      // lands one edge after acceptance.
      IDLE: if (!fifo_empty || push) state_d = STREAM;
      STREAM: begin
        if (pop && head_last) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      // The last vector reaches the bottom row when the counter hits ROWS-1;
      // a stall in that cycle defers both the pulse and the exit.
      DRAIN: begin
        if (!stall_in) begin
          if (drain_cnt_q == LAST_CNT) begin
            done_out    = 1'b1;
            state_d     = IDLE;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Whole-vector shift chain: stage s holds what entered stage 0 s cycles ago,
  // and row r taps stage r. Bubbles (zeros, valid 0) enter whenever nothing
  // is popped, which also flushes the chain in DRAIN and IDLE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < ROWS; s++) stage_dat_q[s] <= '0;
      stage_vld_q <= '0;
    end else if (!stall_in) begin
      stage_dat_q[0] <= pop ? head_vec : '0;
      stage_vld_q[0] <= pop;
      for (int s = 1; s < ROWS; s++) begin
        stage_dat_q[s] <= stage_dat_q[s-1];
        stage_vld_q[s] <= stage_vld_q[s-1];
      end
    end
  end

  always_comb begin
    activations_out       = '0;
    activations_valid_out = '0;
    for (int r = 0; r < ROWS; r++) begin
      activations_out[r]       = stage_dat_q[r][r];
      activations_valid_out[r] = stage_vld_q[r];
    end
  end

endmodule
